// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, timing helpers and command codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, BITS, PARITY, STOP, ACK, WAITIDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // 100 us of clock inhibit, with the system clock given in kHz
  function automatic int unsigned inhibit_cycles(input int unsigned clkfreq_khz);
    return clkfreq_khz / 10;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clkfreq_khz,
                                                 input int unsigned timeout_us);
    longint unsigned prod;
    prod = longint'(clkfreq_khz) * longint'(timeout_us) / 1000;
    return int'(prod);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-flop synchronizer, 8-sample agreement filter, falling-edge strobe.
module ps2_line_filter (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync;
  logic [6:0] hist;
  logic [7:0] win;

  // Current synchronized sample plus the previous seven
  assign win = {hist, sync[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      hist <= {hist[5:0], sync[1]};
      fall <= 1'b0;
      if (win == '1 && !level) begin
        level <= 1'b1;
      end else if (win == '0 && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits, odd parity, stop, device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKFREQ    = 28000,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CYC = inhibit_cycles(CLKFREQ);
  localparam int unsigned TO_CYC  = timeout_cycles(CLKFREQ, TIMEOUT_US);
  localparam int unsigned INH_W   = $clog2(INH_CYC);
  localparam int unsigned TO_W    = $clog2(TO_CYC);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  state_t           state;
  logic [7:0]       shreg;
  logic             par;
  logic [2:0]       bitcnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  wd_cnt;
  logic             ack_ok;
  logic             clk_lvl, fall;
  logic             data_lvl, unused_data_fall;

  ps2_line_filter clk_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2clk_in),
    .level (clk_lvl),
    .fall  (fall)
  );

  ps2_line_filter data_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2data_in),
    .level (data_lvl),
    .fall  (unused_data_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      par        <= 1'b0;
      bitcnt     <= '0;
      inh_cnt    <= '0;
      wd_cnt     <= '0;
      ack_ok     <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (send) begin
          shreg     <= data;
          par       <= ~^data;
          inh_cnt   <= '0;
          ps2clk_oe <= 1'b1;
          busy      <= 1'b1;
          state     <= INHIBIT;
        end
        // RTS pin levels are registered on entry so the inhibit is exactly INH_CYC long
        INHIBIT: if (inh_cnt == INH_LAST) begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b1;
          wd_cnt     <= '0;
          state      <= RTS;
        end else begin
          inh_cnt <= inh_cnt + 1'b1;
        end
        RTS: begin
          bitcnt <= '0;
          state  <= BITS;
        end
        BITS: if (fall) begin
          ps2data_oe <= ~shreg[0];
          shreg      <= shreg >> 1;
          bitcnt     <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) state <= PARITY;
        end
        PARITY: if (fall) begin
          ps2data_oe <= ~par;
          state      <= STOP;
        end
        STOP: if (fall) begin
          ps2data_oe <= 1'b0;
          state      <= ACK;
        end
        ACK: if (fall) begin
          ack_ok <= ~data_lvl;
          state  <= WAITIDLE;
        end
        WAITIDLE: if (clk_lvl && data_lvl) begin
          busy  <= 1'b0;
          done  <= ack_ok;
          error <= ~ack_ok;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog overrides the transfer state; a coincident fall wins over expiry
      if (state != IDLE && state != INHIBIT) begin
        if (fall) begin
          wd_cnt <= '0;
        end else if (wd_cnt == TO_LAST) begin
          error      <= 1'b1;
          done       <= 1'b0;
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  // Scaled clock keeps the run short: inhibit 280 cycles, watchdog 2800 cycles
  localparam int unsigned CLKFREQ    = 2800;
  localparam int unsigned TIMEOUT_US = 1000;
  localparam int INH  = 280;
  localparam int TO   = 2800;
  localparam int HALF = 112;  // 12.5 kHz device clock at 2.8 MHz

  localparam logic [1:0] R_DONE = 2'b10;
  localparam logic [1:0] R_ERR  = 2'b01;

  logic       clk = 1'b0;
  logic       rst, send;
  logic [7:0] data;
  logic       ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
  logic       busy, done, error;
  logic       dev_clk, dev_data;

  int vectors = 0;
  int miscompares = 0;
  int dev_mode = 0;   // 0 ack, 1 nack, 2 silent, 3 stop after 4 clocks
  int dev_count = 0;

  logic [9:0] exp_frame[$];  // {stop, parity, data} as read by the device
  logic [1:0] exp_res[$];

  assign ps2clk_in  = ~ps2clk_oe & dev_clk;
  assign ps2data_in = ~ps2data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(.CLKFREQ(CLKFREQ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe),
    .data       (data),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Result monitor: every done/error pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (done || error) begin
      if (exp_res.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b expected none", done, error);
      end else begin
        check("result", int'({done, error}), int'(exp_res.pop_front()));
      end
    end
  end

  // Device model: waits for request-to-send, clocks the frame, checks what it read
  initial begin : device
    logic [9:0] got;
    logic [9:0] exp;
    int mode;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    forever begin
      @(negedge clk);
      while (!(ps2data_in == 1'b0 && ps2clk_in == 1'b1 && busy)) @(negedge clk);
      mode = dev_mode;
      dev_count = 0;
      got = '0;
      if (mode != 2) begin
        repeat (40) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          if (mode == 3 && k == 5) break;
          dev_clk = 1'b0;
          repeat (HALF) @(negedge clk);
          dev_clk = 1'b1;
          if (k <= 10) got[k-1] = ps2data_in;
          dev_count = k;
          if (k == 10 && mode == 0) dev_data = 1'b0;
          repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
        if (mode <= 1) begin
          if (exp_frame.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", got);
          end else begin
            exp = exp_frame.pop_front();
            check("frame", int'(got), int'(exp));
          end
        end
      end
      while (!(ps2data_in && !busy)) @(negedge clk);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int cnt;
    @(negedge clk);
    data = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("busy_after_send", int'(busy), 1);
    check("clkoe_after_send", int'(ps2clk_oe), 1);
    cnt = 0;
    while (ps2clk_oe && cnt < INH + 50) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("rts_data_oe", int'(ps2data_oe), 1);
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while (busy && t < bound) begin
      t++;
      @(negedge clk);
    end
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin : stim
    int t;
    rst  = 1'b1;
    send = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", int'(ps2clk_oe), 0);
    check("rst_data_oe", int'(ps2data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1 (six ones), stop 1, ACK
    dev_mode = 0;
    exp_frame.push_back(10'h3ED);
    exp_res.push_back(R_DONE);
    send_byte(CMD_SET_LEDS);
    wait_idle(10000);

    // 0xFF: eight ones, parity 1
    exp_frame.push_back(10'h3FF);
    exp_res.push_back(R_DONE);
    send_byte(CMD_RESET);
    wait_idle(10000);

    // 0x00 with NACK: parity 1, error pulse
    dev_mode = 1;
    exp_frame.push_back(10'h300);
    exp_res.push_back(R_ERR);
    send_byte(8'h00);
    wait_idle(10000);

    // 0xF4 to a silent device: watchdog fires TO cycles after RTS entry
    dev_mode = 2;
    exp_res.push_back(R_ERR);
    send_byte(CMD_ENABLE);
    t = 0;
    while (!error && t < TO + 100) begin
      @(negedge clk);
      t++;
    end
    check("timeout_cycles", t, TO);
    check("timeout_clk_oe", int'(ps2clk_oe), 0);
    check("timeout_data_oe", int'(ps2data_oe), 0);
    check("timeout_busy", int'(busy), 0);
    check("timeout_state", int'(dut.state), int'(IDLE));
    repeat (20) @(negedge clk);

    // Reset after four data bits: lines released, no pulse
    dev_mode = 3;
    send_byte(CMD_SET_LEDS);
    t = 0;
    while (dev_count != 4 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("four_bits_clocked", dev_count, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", int'(ps2clk_oe), 0);
    check("midrst_data_oe", int'(ps2data_oe), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (400) @(negedge clk);

    dev_mode = 0;
    exp_frame.push_back(10'h3ED);
    exp_res.push_back(R_DONE);
    send_byte(CMD_SET_LEDS);
    wait_idle(10000);

    // send of 0x55 during an active 0xED transfer is ignored
    exp_frame.push_back(10'h3ED);
    exp_res.push_back(R_DONE);
    send_byte(CMD_SET_LEDS);
    repeat (500) @(negedge clk);
    data = 8'h55;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_idle(10000);
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) t++;
    end
    check("no_restart", t, 0);

    repeat (300) @(negedge clk);
    check("result_queue_drained", exp_res.size(), 0);
    check("frame_queue_drained", exp_frame.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
